// File: rtl/instruction_fetch.sv
// Front-end fetch stage: issues sequential word fetches over a single-outstanding
// req/ack port, buffers returned words in a prefetch FIFO and feeds decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        m_req_o,
  output logic [31:0] m_addr_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_data_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        stall_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o
);

  localparam logic [31:0] NOP = 32'hE320_F000;
  localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW  = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic          req_nxt;
  logic [31:0]   addr_nxt;

  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_after;

  logic [31:0]   target;
  logic [31:0]   addr_inc;
  logic          accept, out_take, fifo_empty;
  logic          push, pop, bypass;

  // Datapath control shared by the FSM, the FIFO and the output stage.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    target      = {branch_addr_i[31:2], 2'b00};
    addr_inc    = m_addr_o + 32'd4;
    fifo_empty  = (count == '0);
    accept      = (state == WAIT) && m_ack_i && !branch_i;
    out_take    = !branch_i && !stall_i;
    pop         = out_take && !fifo_empty;
    // With an empty FIFO the acked word goes straight to the output register.
    bypass      = out_take && fifo_empty && accept;
    push        = accept && !bypass;
    count_after = count;
    if (push && !pop) begin
      count_after = count + CW'(1);
    end else if (pop && !push) begin
      count_after = count - CW'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_nxt      = m_req_o;
    addr_nxt     = m_addr_o;
    case (state)
      IDLE: begin
        req_nxt = 1'b0;
        if (branch_i) begin
          fetch_pc_nxt = target;
        end else if (count < FULL) begin
          state_nxt = WAIT;
          req_nxt   = 1'b1;
          addr_nxt  = fetch_pc;
        end
      end
      WAIT: begin
        if (m_ack_i && branch_i) begin
          fetch_pc_nxt = target;
          addr_nxt     = target;
        end else if (m_ack_i) begin
          fetch_pc_nxt = addr_inc;
          if (count_after < FULL) begin
            addr_nxt = addr_inc;
          end else begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end
        end else if (branch_i) begin
          state_nxt    = DISCARD;
          fetch_pc_nxt = target;
        end
      end
      DISCARD: begin
        // The stale request must complete before the redirected one is issued.
        if (m_ack_i && branch_i) begin
          state_nxt    = WAIT;
          fetch_pc_nxt = target;
          addr_nxt     = target;
        end else if (m_ack_i) begin
          state_nxt = WAIT;
          addr_nxt  = fetch_pc;
        end else if (branch_i) begin
          fetch_pc_nxt = target;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the pre-edge values of each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      m_req_o  <= 1'b0;
      m_addr_o <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      m_req_o  <= req_nxt;
      m_addr_o <= addr_nxt;
    end
  end

  // NOTE: FIFO storage has no reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= m_addr_o;
      data_mem[wr_ptr] <= m_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (branch_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_after;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_o       <= NOP;
      pc_o          <= '0;
      instr_valid_o <= 1'b0;
    end else if (branch_i) begin
      instr_o       <= NOP;
      instr_valid_o <= 1'b0;
    end else if (stall_i) begin
      instr_o       <= instr_o;
      pc_o          <= pc_o;
      instr_valid_o <= instr_valid_o;
    end else if (pop) begin
      instr_o       <= data_mem[rd_ptr];
      pc_o          <= addr_mem[rd_ptr];
      instr_valid_o <= 1'b1;
    end else if (bypass) begin
      instr_o       <= m_data_i;
      pc_o          <= m_addr_o;
      instr_valid_o <= 1'b1;
    end else begin
      instr_o       <= NOP;
      instr_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, backpressure,
// branch redirects, address wrap and asynchronous mid-run reset.
module tb_instruction_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'hE320_F000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req_o;
  logic [31:0] m_addr_o;
  logic        m_ack_i;
  logic [31:0] m_data_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        stall_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;

  logic ack_auto;
  logic ack_man;
  int   checks = 0;
  int   errors = 0;
  int   acks;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .m_req_o       (m_req_o),
    .m_addr_o      (m_addr_o),
    .m_ack_i       (m_ack_i),
    .m_data_i      (m_data_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .stall_i       (stall_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o)
  );

  always #5 clk = ~clk;

  // Memory model: word content is a fixed function of its address.
  assign m_ack_i  = ack_auto ? m_req_o : ack_man;
  assign m_data_i = m_addr_o ^ KEY;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    ack_auto      = 1'b0;
    ack_man       = 1'b1;
    branch_i      = 1'b1;
    branch_addr_i = 32'h1234_5678;
    stall_i       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",   32'(m_req_o), 32'd0);
    check("rst_addr",  m_addr_o, 32'h0);
    check("rst_instr", instr_o, NOP);
    check("rst_pc",    pc_o, 32'h0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);

    // Streaming: memory acks every request.
    branch_i = 1'b0;
    stall_i  = 1'b0;
    ack_man  = 1'b0;
    ack_auto = 1'b1;
    rst      = 1'b0;
    tick();
    check("first_req",   32'(m_req_o), 32'd1);
    check("first_addr",  m_addr_o, 32'h0);
    check("first_valid", 32'(instr_valid_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stream_pc",    pc_o, 32'(4 * i));
      check("stream_instr", instr_o, 32'(4 * i) ^ KEY);
      check("stream_valid", 32'(instr_valid_o), 32'd1);
    end

    // Backpressure: output holds pc 20, FIFO absorbs DEPTH more words.
    stall_i = 1'b1;
    acks    = 0;
    for (int c = 0; c < 10 && m_req_o; c++) begin
      if (m_ack_i) acks++;
      tick();
    end
    check("bp_acks",  32'(acks), 32'(DEPTH));
    check("bp_req",   32'(m_req_o), 32'd0);
    check("bp_pc",    pc_o, 32'd20);
    check("bp_valid", 32'(instr_valid_o), 32'd1);
    tick();
    check("bp_idle_req", 32'(m_req_o), 32'd0);
    check("bp_hold_pc",  pc_o, 32'd20);

    stall_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("drain_pc",    pc_o, 32'(24 + 4 * i));
      check("drain_instr", instr_o, 32'(24 + 4 * i) ^ KEY);
      check("drain_valid", 32'(instr_valid_o), 32'd1);
    end

    // Asynchronous reset while a request is outstanding.
    check("pre_rst_req", 32'(m_req_o), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_req",   32'(m_req_o), 32'd0);
    check("arst_addr",  m_addr_o, 32'h0);
    check("arst_instr", instr_o, NOP);
    check("arst_valid", 32'(instr_valid_o), 32'd0);
    tick();
    rst           = 1'b0;
    ack_auto      = 1'b0;
    ack_man       = 1'b0;
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_0010;
    tick();
    check("br_idle_req", 32'(m_req_o), 32'd0);
    branch_i = 1'b0;
    tick();
    check("req10_req",  32'(m_req_o), 32'd1);
    check("req10_addr", m_addr_o, 32'h10);

    // Branch while outstanding: the 0x10 word must be discarded.
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_0100;
    tick();
    branch_i = 1'b0;
    check("disc_addr",  m_addr_o, 32'h10);
    check("disc_valid", 32'(instr_valid_o), 32'd0);
    tick();
    tick();
    check("disc_hold_addr", m_addr_o, 32'h10);
    check("disc_hold_req",  32'(m_req_o), 32'd1);
    ack_man = 1'b1;
    tick();
    check("redir_addr",  m_addr_o, 32'h100);
    check("redir_valid", 32'(instr_valid_o), 32'd0);
    check("redir_instr", instr_o, NOP);
    tick();
    check("tgt_pc",    pc_o, 32'h100);
    check("tgt_instr", instr_o, 32'h100 ^ KEY);
    check("tgt_valid", 32'(instr_valid_o), 32'd1);
    check("tgt_addr",  m_addr_o, 32'h104);

    // Branch with simultaneous ack and stall; FIFO holds 0x104 beforehand.
    stall_i = 1'b1;
    tick();
    check("stall_pc", pc_o, 32'h100);
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_0202;
    tick();
    check("bas_instr", instr_o, NOP);
    check("bas_valid", 32'(instr_valid_o), 32'd0);
    check("bas_pc",    pc_o, 32'h100);
    check("bas_addr",  m_addr_o, 32'h200);
    check("bas_req",   32'(m_req_o), 32'd1);
    branch_i = 1'b0;
    stall_i  = 1'b0;
    tick();
    check("flush_pc",    pc_o, 32'h200);
    check("flush_valid", 32'(instr_valid_o), 32'd1);

    // Address wrap at the top of the 32-bit space.
    branch_i      = 1'b1;
    branch_addr_i = 32'hFFFF_FFFF;
    tick();
    check("wrap_addr",  m_addr_o, 32'hFFFF_FFFC);
    check("wrap_valid", 32'(instr_valid_o), 32'd0);
    branch_i = 1'b0;
    tick();
    check("wrap_pc",   pc_o, 32'hFFFF_FFFC);
    check("wrap_next", m_addr_o, 32'h0);
    tick();
    check("wrap0_pc",    pc_o, 32'h0);
    check("wrap0_instr", instr_o, KEY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
